// File: rtl/id_inst_queue.sv
// ---------------------------------------------------------------------------
// id_inst_queue
//   Instruction queue between IF and ID. It buffers up to DEPTH fetched
//   instructions, each with its PC and fetch-exception info, so IF can keep
//   fetching while ID stalls. Both sides use the valid/allowin handshake.
//   wb_ClrStpJmp_in empties the queue. id_redirect_in keeps only the head,
//   which is the delay slot of the branch that has already left.
//
//   Optional feature (compile-time macro ID_QUEUE_BYPASS_EN):
//     When the queue is empty, an incoming instruction is presented at the
//     head in the same cycle. If ID takes it in that cycle, it is not stored.
// ---------------------------------------------------------------------------
module id_inst_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] INI_INST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid_in,
    output logic             q_allowin_out,
    input  logic [31:0]      if_PC_in,
    input  logic [31:0]      if_Instruct_in,
    input  logic             if_exception_in,
    input  logic [4:0]       if_ExcCode_in,
    input  logic [31:0]      if_error_VAddr_in,
    input  logic             id_allowin_in,
    output logic             q_valid_out,
    output logic [31:0]      q_PC_out,
    output logic [31:0]      q_Instruct_out,
    output logic             q_exception_out,
    output logic [4:0]       q_ExcCode_out,
    output logic [31:0]      q_error_VAddr_out,
    output logic [PTR_W:0]   q_count_out,
    input  logic             wb_ClrStpJmp_in,
    input  logic             id_redirect_in
);

    // One queue slot: an instruction together with its fetch context.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  exc_code;
        logic [31:0] err_vaddr;
    } entry_t;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    // Head contents shown whenever there is nothing valid to present.
    localparam entry_t IDLE_ENTRY = '{
        pc:        32'h0,
        inst:      INI_INST,
        exc:       1'b0,
        exc_code:  5'h0,
        err_vaddr: 32'h0
    };

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count;

    logic [PTR_W-1:0]   rd_ptr_nxt, wr_ptr_nxt;
    logic [PTR_W:0]     count_nxt;
    logic               wr_en;

    entry_t             in_entry;
    entry_t             head;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               bypass;
    logic               pass_through;

    assign in_entry = '{
        pc:        if_PC_in,
        inst:      if_Instruct_in,
        exc:       if_exception_in,
        exc_code:  if_ExcCode_in,
        err_vaddr: if_error_VAddr_in
    };

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // allowin depends only on stored occupancy, so there is no combinational
    // path from id_allowin_in back to IF.
    assign q_allowin_out = ~full;

`ifdef ID_QUEUE_BYPASS_EN
    // Empty queue, incoming instruction, and no flush or redirect pending.
    assign bypass = empty & if_valid_in & ~wb_ClrStpJmp_in & ~id_redirect_in;
`else
    assign bypass = 1'b0;
`endif

    assign q_valid_out  = ~empty | bypass;
    assign push         = if_valid_in & q_allowin_out;
    assign pop          = q_valid_out & id_allowin_in;
    // A bypassed instruction taken by ID in the same cycle is never stored.
    assign pass_through = bypass & pop;

    // Head source: bypassed input, stored entry, or idle values when empty.
    always_comb begin
        if (bypass) begin
            head = in_entry;
        end else if (empty) begin
            head = IDLE_ENTRY;
        end else begin
            head = mem[rd_ptr];
        end
    end

    assign q_PC_out          = head.pc;
    assign q_Instruct_out    = head.inst;
    assign q_exception_out   = head.exc;
    assign q_ExcCode_out     = head.exc_code;
    assign q_error_VAddr_out = head.err_vaddr;
    assign q_count_out       = count;

    // Next pointers and occupancy: flush, then redirect, then normal push/pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        wr_en      = 1'b0;

        if (wb_ClrStpJmp_in) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else if (id_redirect_in) begin
            if (!empty) begin
                // The head is the delay slot; everything behind it is wrong-path.
                wr_ptr_nxt = rd_ptr + PTR_ONE;
                if (pop) begin
                    rd_ptr_nxt = rd_ptr + PTR_ONE;
                    count_nxt  = '0;
                end else begin
                    count_nxt  = CNT_ONE;
                end
            end else if (push) begin
                // Nothing queued yet: the incoming instruction is the delay slot.
                wr_en      = 1'b1;
                wr_ptr_nxt = wr_ptr + PTR_ONE;
                count_nxt  = CNT_ONE;
            end
        end else if (!pass_through) begin
            if (push) begin
                wr_en      = 1'b1;
                wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset. An entry is only read
        // after it has been written, and the empty head shows IDLE_ENTRY.
        if (wr_en) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_id_inst_queue
//   Directed, table-driven bench for id_inst_queue (DEPTH=4). Each table row
//   gives the inputs for one clock and the occupancy/head expected right after
//   that edge. Hand-written sequences cover exception entries and head latency
//   (with and without ID_QUEUE_BYPASS_EN).
// ---------------------------------------------------------------------------
module tb_id_inst_queue;

    localparam int          DEPTH    = 4;
    localparam int          PTR_W    = 2;
    localparam logic [31:0] INI_INST = 32'h0000_0000;

    logic             clk;
    logic             rst_n;
    logic             if_valid_in;
    logic             q_allowin_out;
    logic [31:0]      if_PC_in;
    logic [31:0]      if_Instruct_in;
    logic             if_exception_in;
    logic [4:0]       if_ExcCode_in;
    logic [31:0]      if_error_VAddr_in;
    logic             id_allowin_in;
    logic             q_valid_out;
    logic [31:0]      q_PC_out;
    logic [31:0]      q_Instruct_out;
    logic             q_exception_out;
    logic [4:0]       q_ExcCode_out;
    logic [31:0]      q_error_VAddr_out;
    logic [PTR_W:0]   q_count_out;
    logic             wb_ClrStpJmp_in;
    logic             id_redirect_in;

    int n_cmp  = 0;
    int n_fail = 0;

    id_inst_queue #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W),
        .INI_INST (INI_INST)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_valid_in       (if_valid_in),
        .q_allowin_out     (q_allowin_out),
        .if_PC_in          (if_PC_in),
        .if_Instruct_in    (if_Instruct_in),
        .if_exception_in   (if_exception_in),
        .if_ExcCode_in     (if_ExcCode_in),
        .if_error_VAddr_in (if_error_VAddr_in),
        .id_allowin_in     (id_allowin_in),
        .q_valid_out       (q_valid_out),
        .q_PC_out          (q_PC_out),
        .q_Instruct_out    (q_Instruct_out),
        .q_exception_out   (q_exception_out),
        .q_ExcCode_out     (q_ExcCode_out),
        .q_error_VAddr_out (q_error_VAddr_out),
        .q_count_out       (q_count_out),
        .wb_ClrStpJmp_in   (wb_ClrStpJmp_in),
        .id_redirect_in    (id_redirect_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus plus the state expected just after that edge.
    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        ida;
        logic        clr;
        logic        rdr;
        logic [2:0]  cnt;
        logic [31:0] hpc;
    } vec_t;

    // Instruction word tied to its PC so the head word can be predicted.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h2400_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic ida,
                         input logic clr, input logic rdr);
        if_valid_in       = vld;
        if_PC_in          = pc;
        if_Instruct_in    = inst_of(pc);
        if_exception_in   = 1'b0;
        if_ExcCode_in     = 5'h0;
        if_error_VAddr_in = 32'h0;
        id_allowin_in     = ida;
        wb_ClrStpJmp_in   = clr;
        id_redirect_in    = rdr;
    endtask

    task automatic check_head(input string tag, input logic [2:0] cnt, input logic [31:0] hpc);
        logic vld_e;
        vld_e = (cnt != 3'd0);
        check({tag, " count"},  32'(q_count_out),   32'(cnt));
        check({tag, " valid"},  32'(q_valid_out),   32'(vld_e));
        check({tag, " allowin"}, 32'(q_allowin_out), 32'(cnt != 3'(DEPTH)));
        check({tag, " pc"},     q_PC_out,           vld_e ? hpc : 32'h0);
        check({tag, " inst"},   q_Instruct_out,     vld_e ? inst_of(hpc) : INI_INST);
        check({tag, " exc"},    32'(q_exception_out), 32'h0);
    endtask

    vec_t vecs [$];

    initial begin
        // Fill: fill to full; wrap-around drain; push+pop at 1; flush;
        // redirect without pop; redirect with pop; redirect on empty; flush over redirect.
        vecs = '{
            '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 3'd1, 32'hBFC0_0000},
            '{1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 3'd2, 32'hBFC0_0000},
            '{1'b1, 32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 3'd3, 32'hBFC0_0000},
            '{1'b1, 32'hBFC0_000C, 1'b0, 1'b0, 1'b0, 3'd4, 32'hBFC0_0000},
            '{1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 3'd4, 32'hBFC0_0000},
            '{1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 1'b0, 3'd3, 32'hBFC0_0004},
            '{1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 1'b0, 3'd3, 32'hBFC0_0008},
            '{1'b1, 32'hBFC0_0014, 1'b1, 1'b0, 1'b0, 3'd3, 32'hBFC0_000C},
            '{1'b1, 32'hBFC0_0018, 1'b1, 1'b0, 1'b0, 3'd3, 32'hBFC0_0010},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd2, 32'hBFC0_0014},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd1, 32'hBFC0_0018},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0020},
            '{1'b1, 32'h0000_0024, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_0024},
            '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0024},
            '{1'b1, 32'h0000_002C, 1'b0, 1'b0, 1'b0, 3'd3, 32'h0000_0024},
            '{1'b1, 32'h0000_0030, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0100},
            '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0100},
            '{1'b1, 32'h0000_0108, 1'b0, 1'b0, 1'b0, 3'd3, 32'h0000_0100},
            '{1'b1, 32'h0000_010C, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0100},
            '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0100},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_0200},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0300},
            '{1'b1, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0300},
            '{1'b1, 32'h0000_0308, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_040C, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_040C},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0500},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_0000},
            '{1'b1, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0600},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0000_0000}
        };

        // Synchronous reset with idle inputs.
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_head("reset", 3'd0, 32'h0);
        check("reset exccode", 32'(q_ExcCode_out), 32'h0);
        check("reset vaddr", q_error_VAddr_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: drive at the falling edge, check just after the rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].pc, vecs[i].ida, vecs[i].clr, vecs[i].rdr);
            @(posedge clk);
            #1;
            check_head($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].hpc);
        end

        // Exception entry travels unchanged, in order, behind nothing special.
        @(negedge clk);
        drive(1'b1, 32'h0000_0700, 1'b0, 1'b0, 1'b0);
        if_exception_in   = 1'b1;
        if_ExcCode_in     = 5'h04;
        if_error_VAddr_in = 32'h0000_0003;
        @(negedge clk);
        drive(1'b1, 32'h0000_0704, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("exc count", 32'(q_count_out), 32'd2);
        check("exc head pc", q_PC_out, 32'h0000_0700);
        check("exc head flag", 32'(q_exception_out), 32'h1);
        check("exc head code", 32'(q_ExcCode_out), 32'h04);
        check("exc head vaddr", q_error_VAddr_out, 32'h0000_0003);
        id_allowin_in = 1'b1;
        @(posedge clk);
        #1;
        check("exc next pc", q_PC_out, 32'h0000_0704);
        check("exc next flag", 32'(q_exception_out), 32'h0);
        check("exc next code", 32'(q_ExcCode_out), 32'h0);
        check("exc next vaddr", q_error_VAddr_out, 32'h0);
        @(posedge clk);
        #1;
        check("exc drained", 32'(q_count_out), 32'd0);

        // Head latency on an empty queue with ID ready.
        @(negedge clk);
        drive(1'b1, 32'h0000_0800, 1'b1, 1'b0, 1'b0);
        #1;
`ifdef ID_QUEUE_BYPASS_EN
        check("byp same-cycle valid", 32'(q_valid_out), 32'h1);
        check("byp same-cycle pc", q_PC_out, 32'h0000_0800);
        check("byp same-cycle inst", q_Instruct_out, inst_of(32'h0000_0800));
        @(posedge clk);
        #1;
        check("byp count stays 0", 32'(q_count_out), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("byp idle valid", 32'(q_valid_out), 32'h0);
`else
        check("nobyp same-cycle valid", 32'(q_valid_out), 32'h0);
        check("nobyp same-cycle pc", q_PC_out, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("nobyp next valid", 32'(q_valid_out), 32'h1);
        check("nobyp next pc", q_PC_out, 32'h0000_0800);
        check("nobyp next count", 32'(q_count_out), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
